// File: rtl/conv_frame_ctrl_pkg.sv
// Shared definitions for the convolutional-encoder frame controller:
// default code parameters, generator constants and FSM state encodings.
package conv_frame_ctrl_pkg;

   localparam int K_DEF       = 4;
   localparam int M_DEF       = K_DEF - 1;
   localparam int LEN_W_DEF   = 16;
   localparam int MAX_LEN_DEF = 256;

   // Generator polynomials for K=4 (octal 17 and 15), shared with encoder/decoder
   localparam logic [K_DEF-1:0] G0_DEF = 4'b1111;
   localparam logic [K_DEF-1:0] G1_DEF = 4'b1101;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_SEND   = 3'd1,
      ST_TAIL   = 3'd2,
      ST_FILL   = 3'd3,
      ST_SEED   = 3'd4,
      ST_REPLAY = 3'd5
   } state_t;

   // A start is refused when the frame is empty, or when a tail-biting frame
   // is too short to supply a full seed or too long for the replay buffer.
   function automatic logic cfg_reject(input logic [31:0] len,
                                       input logic        tail_biting,
                                       input logic [31:0] m,
                                       input logic [31:0] max_len);
      return (len == 32'd0) ||
             (tail_biting && ((len < m) || (len > max_len)));
   endfunction

endpackage

// File: rtl/conv_bit_buffer.sv
// Single-bit frame store for tail-biting replay: synchronous write,
// combinational read, no reset (contents are don't-care after reset).
module conv_bit_buffer
   import conv_frame_ctrl_pkg::*;
#(
   parameter int DEPTH = MAX_LEN_DEF,
   parameter int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
)(
   input  logic             clk,
   input  logic             i_we,
   input  logic [IDX_W-1:0] i_wr_idx,
   input  logic             i_wr_bit,
   input  logic [IDX_W-1:0] i_rd_idx,
   output logic             o_rd_bit
);

   logic r_mem [DEPTH];

   // write one info bit per accepted transfer
   always_ff @(posedge clk) begin
      if (i_we) r_mem[i_wr_idx] <= i_wr_bit;
   end

   assign o_rd_bit = r_mem[i_rd_idx];

endmodule

// File: rtl/conv_frame_ctrl.sv
// Frame controller in front of the rate-1/2 convolutional encoder.
// Terminated frames pass through and get M zero tail bits; tail-biting
// frames are buffered, the encoder is seeded with the last M bits, and the
// frame is replayed without a tail.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | waiting for start; validates config, raises cfg_err
//  ST_SEND   | terminated: zero-latency pass-through of info bits
//  ST_TAIL   | terminated: M zero tail beats
//  ST_FILL   | tail-biting: store info bits, track last M in seed register
//  ST_SEED   | tail-biting: one-cycle seed load into the encoder
//  ST_REPLAY | tail-biting: replay buffered bits to the encoder
module conv_frame_ctrl
   import conv_frame_ctrl_pkg::*;
#(
   parameter int K       = K_DEF,
   parameter int M       = K - 1,
   parameter int LEN_W   = LEN_W_DEF,
   parameter int MAX_LEN = MAX_LEN_DEF
)(
   input  logic             clk,
   input  logic             rst,
   input  logic             i_start,
   input  logic [LEN_W-1:0] i_frame_len,
   input  logic             i_tail_biting,
   input  logic             i_s_valid,
   output logic             o_s_ready,
   input  logic             i_s_bit,
   input  logic             i_enc_ready,
   output logic             o_enc_in_valid,
   output logic             o_enc_in_bit,
   output logic             o_enc_seed_load,
   output logic [M-1:0]     o_enc_seed_value,
   output logic             o_enc_sof,
   output logic             o_enc_eof,
   output logic             o_busy,
   output logic             o_frame_done,
   output logic             o_cfg_err
);

   localparam int               IDX_W       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
   localparam logic [LEN_W-1:0] C_TAIL_LAST = LEN_W'(M - 1);

   state_t           r_state;
   logic [LEN_W-1:0] r_len;
   logic [LEN_W-1:0] r_cnt;
   logic [M-1:0]     r_sh;
   logic             r_frame_done;
   logic             r_cfg_err;

   logic             w_xfer;
   logic             w_cnt_last;
   logic             w_cfg_bad;
   logic             w_first;
   logic             w_last;
   logic             w_rd_bit;
   logic             w_buf_we;

   assign w_xfer     = i_s_valid & o_s_ready;
   assign w_cnt_last = (r_cnt == (r_len - LEN_W'(1)));
   assign w_cfg_bad  = cfg_reject(32'(i_frame_len), i_tail_biting, 32'(M), 32'(MAX_LEN));
   assign w_buf_we   = (r_state == ST_FILL) & w_xfer;

   conv_bit_buffer #(
      .DEPTH (MAX_LEN),
      .IDX_W (IDX_W)
   ) u_buf (
      .clk      (clk),
      .i_we     (w_buf_we),
      .i_wr_idx (r_cnt[IDX_W-1:0]),
      .i_wr_bit (i_s_bit),
      .i_rd_idx (r_cnt[IDX_W-1:0]),
      .o_rd_bit (w_rd_bit)
   );

   // per-state handshake and encoder drive; pass-through must stay zero-latency
   always_comb begin
      o_s_ready       = 1'b0;
      o_enc_in_valid  = 1'b0;
      o_enc_in_bit    = 1'b0;
      o_enc_seed_load = 1'b0;
      w_first         = 1'b0;
      w_last          = 1'b0;
      case (r_state)
         ST_SEND: begin
            o_s_ready      = i_enc_ready;
            o_enc_in_valid = i_s_valid & i_enc_ready;
            o_enc_in_bit   = i_s_bit;
            w_first        = (r_cnt == '0);
         end
         ST_TAIL: begin
            o_enc_in_valid = i_enc_ready;
            w_last         = (r_cnt == C_TAIL_LAST);
         end
         ST_FILL: begin
            o_s_ready = 1'b1;
         end
         ST_SEED: begin
            o_enc_seed_load = 1'b1;
         end
         ST_REPLAY: begin
            o_enc_in_valid = i_enc_ready;
            o_enc_in_bit   = w_rd_bit;
            w_first        = (r_cnt == '0);
            w_last         = w_cnt_last;
         end
         default: ;
      endcase
   end

   assign o_enc_sof        = o_enc_in_valid & w_first;
   assign o_enc_eof        = o_enc_in_valid & w_last;
   assign o_enc_seed_value = r_sh;
   assign o_busy           = (r_state != ST_IDLE);
   assign o_frame_done     = r_frame_done;
   assign o_cfg_err        = r_cfg_err;

   // frame sequencing, beat counter and seed shift register; stalls hold everything
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_len        <= '0;
         r_cnt        <= '0;
         r_sh         <= '0;
         r_frame_done <= 1'b0;
         r_cfg_err    <= 1'b0;
      end else begin
         r_frame_done <= 1'b0;
         r_cfg_err    <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  if (w_cfg_bad) begin
                     r_cfg_err <= 1'b1;
                  end else begin
                     r_len   <= i_frame_len;
                     r_cnt   <= '0;
                     r_state <= i_tail_biting ? ST_FILL : ST_SEND;
                  end
               end
            end
            ST_SEND: begin
               if (o_enc_in_valid) begin
                  if (w_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= ST_TAIL;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            ST_TAIL: begin
               if (o_enc_in_valid) begin
                  if (r_cnt == C_TAIL_LAST) begin
                     r_cnt        <= '0;
                     r_frame_done <= 1'b1;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            ST_FILL: begin
               if (w_xfer) begin
                  // newest bit enters at the top so sh[M-1] ends as the last info bit
                  r_sh <= M'({i_s_bit, r_sh} >> 1);
                  if (w_cnt_last) begin
                     r_cnt   <= '0;
                     r_state <= ST_SEED;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            ST_SEED: begin
               r_cnt   <= '0;
               r_state <= ST_REPLAY;
            end
            ST_REPLAY: begin
               if (o_enc_in_valid) begin
                  if (w_cnt_last) begin
                     r_cnt        <= '0;
                     r_frame_done <= 1'b1;
                     r_state      <= ST_IDLE;
                  end else begin
                     r_cnt <= r_cnt + LEN_W'(1);
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_frame_ctrl.sv
// Self-checking bench for conv_frame_ctrl: directed frames plus randomized
// frames compared against a frame-level reference (expected beat list and seed).
module tb_conv_frame_ctrl;
   import conv_frame_ctrl_pkg::*;

   localparam int K       = 4;
   localparam int M       = 3;
   localparam int LEN_W   = 16;
   localparam int MAX_LEN = 256;

   logic             clk = 1'b0;
   logic             rst;
   logic             i_start;
   logic [LEN_W-1:0] i_frame_len;
   logic             i_tail_biting;
   logic             i_s_valid;
   logic             o_s_ready;
   logic             i_s_bit;
   logic             i_enc_ready;
   logic             o_enc_in_valid;
   logic             o_enc_in_bit;
   logic             o_enc_seed_load;
   logic [M-1:0]     o_enc_seed_value;
   logic             o_enc_sof;
   logic             o_enc_eof;
   logic             o_busy;
   logic             o_frame_done;
   logic             o_cfg_err;

   int n_checks = 0;
   int n_errors = 0;
   bit g_bits [MAX_LEN];

   conv_frame_ctrl #(.K(K), .M(M), .LEN_W(LEN_W), .MAX_LEN(MAX_LEN)) dut (
      .clk              (clk),
      .rst              (rst),
      .i_start          (i_start),
      .i_frame_len      (i_frame_len),
      .i_tail_biting    (i_tail_biting),
      .i_s_valid        (i_s_valid),
      .o_s_ready        (o_s_ready),
      .i_s_bit          (i_s_bit),
      .i_enc_ready      (i_enc_ready),
      .o_enc_in_valid   (o_enc_in_valid),
      .o_enc_in_bit     (o_enc_in_bit),
      .o_enc_seed_load  (o_enc_seed_load),
      .o_enc_seed_value (o_enc_seed_value),
      .o_enc_sof        (o_enc_sof),
      .o_enc_eof        (o_enc_eof),
      .o_busy           (o_busy),
      .o_frame_done     (o_frame_done),
      .o_cfg_err        (o_cfg_err)
   );

   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
      end
   endtask

   task automatic drive_idle();
      i_start       = 1'b0;
      i_frame_len   = '0;
      i_tail_biting = 1'b0;
      i_s_valid     = 1'b0;
      i_s_bit       = 1'b0;
      i_enc_ready   = 1'b1;
   endtask

   task automatic load_bits(input int len, input logic [31:0] pat);
      for (int i = 0; i < len; i++) g_bits[i] = pat[len-1-i];
   endtask

   task automatic rand_bits(input int len);
      for (int i = 0; i < len; i++) g_bits[i] = 1'($urandom % 2);
   endtask

   // Runs one frame from the current cycle (posedge+1). mode: 0 no stalls,
   // 1 random stalls, 2 enc_ready toggling with random s_valid gaps.
   task automatic run_frame(input bit tb, input int len, input int mode, input bit poke,
                            input int abort_at, input bit started,
                            input bit nx_start, input bit nx_tb, input int nx_len);
      bit           exp_q[$];
      logic [M-1:0] exp_seed;
      int           sent, beats, n, cyc, first_cyc, last_cyc, budget;
      bit           seeded, aborted;
      exp_q = {};
      for (int i = 0; i < len; i++) exp_q.push_back(g_bits[i]);
      if (!tb) for (int i = 0; i < M; i++) exp_q.push_back(1'b0);
      n = exp_q.size();
      exp_seed = '0;
      if (tb) for (int j = 0; j < M; j++) exp_seed[M-1-j] = g_bits[len-1-j];
      sent = 0; beats = 0; cyc = 0; first_cyc = -1; last_cyc = -1;
      seeded = 0; aborted = 0; budget = 8 * len + 100;
      if (!started) begin
         i_start = 1'b1; i_frame_len = LEN_W'(len); i_tail_biting = tb;
         i_s_valid = 1'b0; i_enc_ready = 1'b1;
         @(posedge clk); #1;
      end
      i_start = 1'b0;
      while (beats < n && cyc < budget) begin
         if (abort_at >= 0 && beats == abort_at) begin
            rst = 1'b1; i_enc_ready = 1'b1; i_s_valid = 1'b1;
            @(posedge clk); #1;
            rst = 1'b0;
            @(negedge clk);
            chk_eq("rst_outs", {o_s_ready, o_enc_in_valid, o_enc_in_bit, o_enc_seed_load,
                                o_enc_sof, o_enc_eof, o_busy, o_frame_done, o_cfg_err}, 0);
            chk_eq("rst_seed", o_enc_seed_value, 0);
            @(posedge clk); #1;
            drive_idle();
            aborted = 1;
            break;
         end
         i_start = poke; i_frame_len = '0; i_tail_biting = 1'b0;
         case (mode)
            0: begin i_enc_ready = 1'b1; i_s_valid = 1'b1; end
            1: begin i_enc_ready = ($urandom_range(0, 9) < 7); i_s_valid = ($urandom_range(0, 9) < 7); end
            default: begin i_enc_ready = (cyc % 2 == 0); i_s_valid = 1'($urandom % 2); end
         endcase
         i_s_bit = (sent < len) ? g_bits[sent] : 1'($urandom % 2);
         @(negedge clk);
         chk_eq("busy", o_busy, 1);
         chk_eq("cfg_err_busy", o_cfg_err, 0);
         chk_eq("done_early", o_frame_done, 0);
         if (sent < len) begin
            if (tb) begin
               chk_eq("fill_rdy", o_s_ready, 1);
               chk_eq("fill_noval", o_enc_in_valid, 0);
            end else begin
               chk_eq("send_rdy", o_s_ready, i_enc_ready);
            end
         end else begin
            chk_eq("s_rdy_off", o_s_ready, 0);
         end
         if (tb && sent == len && !seeded) begin
            chk_eq("seed_ld", o_enc_seed_load, 1);
            chk_eq("seed_val", o_enc_seed_value, exp_seed);
            chk_eq("seed_noval", o_enc_in_valid, 0);
            seeded = 1;
         end else begin
            chk_eq("seed_ld_off", o_enc_seed_load, 0);
         end
         if (o_enc_in_valid) begin
            chk_eq("bit", o_enc_in_bit, exp_q[beats]);
            chk_eq("sof", o_enc_sof, beats == 0);
            chk_eq("eof", o_enc_eof, beats == n - 1);
            if (beats == 0) first_cyc = cyc;
            last_cyc = cyc;
            beats++;
         end else begin
            chk_eq("sofeof_noval", {o_enc_sof, o_enc_eof}, 0);
         end
         if (i_s_valid && o_s_ready) sent++;
         @(posedge clk); #1;
         cyc++;
      end
      if (aborted) return;
      chk_eq("beat_count", beats, n);
      chk_eq("xfer_count", sent, len);
      if (tb) chk_eq("seeded", seeded, 1);
      if (mode == 0) begin
         chk_eq("lat_first", first_cyc, tb ? len + 1 : 0);
         chk_eq("contig", last_cyc - first_cyc, n - 1);
      end
      i_start = nx_start; i_frame_len = LEN_W'(nx_len); i_tail_biting = nx_tb;
      i_s_valid = 1'b0; i_enc_ready = 1'b1;
      @(negedge clk);
      chk_eq("frame_done", o_frame_done, 1);
      chk_eq("busy_idle", o_busy, 0);
      chk_eq("idle_noval", o_enc_in_valid, 0);
      @(posedge clk); #1;
      i_start = 1'b0;
   endtask

   task automatic try_bad(input bit tb, input int len);
      i_start = 1'b1; i_frame_len = LEN_W'(len); i_tail_biting = tb;
      @(posedge clk); #1;
      i_start = 1'b0;
      @(negedge clk);
      chk_eq("cfg_err", o_cfg_err, 1);
      chk_eq("cfg_busy", o_busy, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk_eq("cfg_err_pulse", o_cfg_err, 0);
      chk_eq("cfg_busy2", o_busy, 0);
      @(posedge clk); #1;
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ctb, ntb, b2b, pend;
      int clen, nlen;
      rst = 1'b1;
      drive_idle();
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      chk_eq("reset_outs", {o_s_ready, o_enc_in_valid, o_enc_in_bit, o_enc_seed_load,
                            o_enc_sof, o_enc_eof, o_busy, o_frame_done, o_cfg_err}, 0);
      chk_eq("reset_seed", o_enc_seed_value, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // terminated L=5, bits 1,0,1,1,0
      load_bits(5, 32'b10110);
      run_frame(0, 5, 0, 0, -1, 0, 0, 0, 0);
      // tail-biting L=6, bits 1,1,0,1,0,0 (seed 3'b001)
      load_bits(6, 32'b110100);
      run_frame(1, 6, 0, 0, -1, 0, 0, 0, 0);
      // backpressure with start pokes while busy
      rand_bits(4);
      run_frame(0, 4, 2, 1, -1, 0, 0, 0, 0);
      // rejected configurations
      try_bad(1, 2);
      try_bad(0, 0);
      try_bad(1, 257);
      try_bad(1, 0);
      // reset on tail beat 2, then a clean L=3 frame
      rand_bits(4);
      run_frame(0, 4, 0, 0, 5, 0, 0, 0, 0);
      rand_bits(3);
      run_frame(0, 3, 0, 0, -1, 0, 0, 0, 0);
      // length boundaries
      load_bits(1, 32'b1);
      run_frame(0, 1, 0, 0, -1, 0, 0, 0, 0);
      rand_bits(3);
      run_frame(1, 3, 0, 0, -1, 0, 0, 0, 0);
      rand_bits(MAX_LEN);
      run_frame(1, MAX_LEN, 1, 0, -1, 0, 0, 0, 0);
      // back-to-back: start in the frame_done cycle
      rand_bits(5);
      run_frame(0, 5, 0, 0, -1, 0, 1, 0, 4);
      rand_bits(4);
      run_frame(0, 4, 0, 0, -1, 1, 1, 1, 5);
      rand_bits(5);
      run_frame(1, 5, 0, 0, -1, 1, 0, 0, 0);

      // randomized frames, some chained back-to-back
      pend = 0;
      ctb  = 1'($urandom % 2);
      clen = ctb ? $urandom_range(M, 24) : $urandom_range(1, 24);
      for (int f = 0; f < 30; f++) begin
         rand_bits(clen);
         ntb  = 1'($urandom % 2);
         nlen = ntb ? $urandom_range(M, 24) : $urandom_range(1, 24);
         b2b  = (f < 29) && ($urandom % 2 == 1);
         run_frame(ctb, clen, $urandom_range(0, 2), 1'($urandom % 2), -1, pend, b2b, ntb, nlen);
         pend = b2b;
         ctb  = ntb;
         clen = nlen;
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
